load_store_unit: RTL and testbench
==================================

// Module: load_store_unit
// PURPOSE
//  Sequences one data-memory access per request for the single-cycle RISC-V core.
//  Consumes the ALU result as the effective address and rs2 as store data.
//  Drives a valid/ready data-memory port with word address, byte enables and lane-shifted data.
//  Returns sign/zero-extended load data and a done/err status; the core stalls while busy=1.
// PARAMETERS
//  TIMEOUT_CYCLES  16  cycles in REQ without mem_ready before err is raised (>=1, counter width $clog2+1)
// PORTS
//  clk         in   1   single clock, all state updates on rising edge
//  rst         in   1   reset, synchronous, active-low (rst==0 sampled at posedge resets)
//  req         in   1   start access; sampled only in IDLE
//  we          in   1   1=store, 0=load
//  funct3      in   3   000 B, 001 H, 010 W, 100 BU, 101 HU (BU/HU load-only)
//  addr        in   32  effective address (ALU result)
//  wdata       in   32  store data (rs2), low bytes used for B/H
//  rdata       out  32  extended load data, valid while done=1, held until next load completes
//  done        out  1   one-cycle pulse: access completed OK
//  err         out  1   one-cycle pulse: illegal funct3, misaligned (macro) or timeout
//  busy        out  1   1 in any state except IDLE
//  mem_req     out  1   memory request valid
//  mem_we      out  1   memory write enable
//  mem_addr    out  32  {addr[31:2],2'b00}
//  mem_be      out  4   byte enables
//  mem_wdata   out  32  store data replicated/shifted to the addressed lane
//  mem_ready   in   1   memory accepts/completes access in this cycle
//  mem_rdata   in   32  read word, valid when mem_ready=1 on a load
// BEHAVIOUR
//  - Reset: state IDLE; rdata, done, err, busy, mem_req, mem_we, mem_addr, mem_be, mem_wdata, timeout counter = 0.
//  - States IDLE -> REQ -> DONE -> IDLE; IDLE -> ERR -> IDLE; REQ -> ERR on timeout.
//  - IDLE: req=1 latches we/funct3/addr/wdata; illegal funct3 (011,110,111, or we=1 with 1xx) -> ERR, no mem_req.
//    Otherwise -> REQ; mem_req=1 and all mem_* outputs registered, valid from next cycle.
//  - REQ: mem_* held stable until mem_ready=1 sampled; then mem_req=0, -> DONE. Counter +1 per REQ cycle;
//    reaching TIMEOUT_CYCLES without mem_ready -> ERR, mem_req=0. Counter cleared on entering REQ.
//  - Lanes: off=addr[1:0]. B: be=0001<<off, wdata byte at bits 8*off. H: be=0011<<(2*off[1]), half at 16*off[1].
//    W: be=1111. Load extract uses same offset; B/H sign-extend bit 7/15, BU/HU zero-extend.
//  - DONE: done=1 one cycle, rdata updated on loads (unchanged on stores), -> IDLE. ERR: err=1 one cycle, -> IDLE.
//  - Latency: req at cycle 0 -> mem_req high cycle 1; mem_ready sampled at cycle k -> done at k+1 (min 2).
//  - req while busy=1 ignored; mem_ready outside REQ ignored. done and err never both 1.
//  - rst low mid-access: abandons transaction, mem_req=0 after that edge, no done/err pulse.
// CONFIGURATION
//  MISALIGN_TRAP_EN defined: H with addr[0]=1 or W with addr[1:0]!=0 -> ERR, memory never requested.
//  Not defined: misaligned low bits ignored (H uses off[1] only, W uses off 0); access proceeds normally.
// TESTING
//  - SB addr 0x0000_1003 wdata 0x1234_56A5, mem_ready on 1st REQ cycle -> mem_addr 0x1000, be 1000,
//    mem_wdata[31:24]=0xA5, done at cycle 2.
//  - LB addr 0x2002, mem_rdata 0x0080_0000 -> rdata 0xFFFF_FF80; LBU same -> 0x0000_0080; LHU addr 0x2002 -> 0x0000_0080.
//  - LW addr 0x3000, mem_ready after 5 REQ cycles, mem_rdata 0xDEAD_BEEF -> mem_* stable 5 cycles, rdata 0xDEAD_BEEF, done once.
//  - LH addr 0x0001: with MISALIGN_TRAP_EN -> err pulse cycle 1, mem_req never 1; without -> be 0011, done.
//  - mem_ready held 0, TIMEOUT_CYCLES=16 -> err after 16 REQ cycles, mem_req low; funct3=011 -> err, no mem_req.
//  - rst=0 in 3rd REQ cycle -> all outputs 0 next edge; new req after release completes normally.

Source files
------------

// File: rtl/load_store_unit.sv
// +--------------------------------------------------------------------------+
// | load_store_unit: one data-memory access per request, valid/ready port.    |
// | Option macro: MISALIGN_TRAP_EN (trap misaligned H/W instead of masking).  |
// | Revision: 1.0                                                             |
// +--------------------------------------------------------------------------+
`default_nettype none

module load_store_unit #(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic        clk_i,
  input  logic        rst_i,        // active-low, synchronous
  input  logic        req_i,
  input  logic        we_i,
  input  logic [2:0]  funct3_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] rdata_o,
  output logic        done_o,
  output logic        err_o,
  output logic        busy_o,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [31:0] mem_addr_o,
  output logic [3:0]  mem_be_o,
  output logic [31:0] mem_wdata_o,
  input  logic        mem_ready_i,
  input  logic [31:0] mem_rdata_i
);

  localparam int unsigned CW = $clog2(TIMEOUT_CYCLES) + 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;
  localparam logic [1:0] S_ERR  = 2'd3;

  logic [1:0]    state_q, state_d;
  logic [2:0]    f3_q, f3_d;
  logic [1:0]    off_q, off_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [CW-1:0] cnt_inc;
  logic          mem_we_q, mem_we_d;
  logic [31:0]   mem_addr_q, mem_addr_d;
  logic [3:0]    mem_be_q, mem_be_d;
  logic [31:0]   mem_wdata_q, mem_wdata_d;
  logic [31:0]   rdata_q, rdata_d;

  logic          illegal;
  logic          misal;
  logic [3:0]    lane_be;
  logic [31:0]   lane_wdata;
  logic [7:0]    ld_byte;
  logic [15:0]   ld_half;
  logic [31:0]   ld_ext;

  assign cnt_inc = cnt_q + CW'(1);

  // Request decode, evaluated against the live inputs while idle
  always_comb begin
    illegal = (funct3_i == 3'b011) || (funct3_i == 3'b110) ||
              (funct3_i == 3'b111) || (we_i && funct3_i[2]);
`ifdef MISALIGN_TRAP_EN
    misal = ((funct3_i[1:0] == 2'b01) && addr_i[0]) ||
            ((funct3_i[1:0] == 2'b10) && (addr_i[1:0] != 2'b00));
`else
    misal = 1'b0;
`endif
    case (funct3_i[1:0])
      2'b00: begin
        lane_be    = 4'b0001 << addr_i[1:0];
        lane_wdata = {4{wdata_i[7:0]}};
      end
      2'b01: begin
        lane_be    = addr_i[1] ? 4'b1100 : 4'b0011;
        lane_wdata = {2{wdata_i[15:0]}};
      end
      default: begin
        lane_be    = 4'b1111;
        lane_wdata = wdata_i;
      end
    endcase
  end

  // Load extraction uses the offset captured at request time
  always_comb begin
    case (off_q)
      2'd0:    ld_byte = mem_rdata_i[7:0];
      2'd1:    ld_byte = mem_rdata_i[15:8];
      2'd2:    ld_byte = mem_rdata_i[23:16];
      default: ld_byte = mem_rdata_i[31:24];
    endcase
    ld_half = off_q[1] ? mem_rdata_i[31:16] : mem_rdata_i[15:0];
    case (f3_q)
      3'b000:  ld_ext = {{24{ld_byte[7]}}, ld_byte};
      3'b001:  ld_ext = {{16{ld_half[15]}}, ld_half};
      3'b100:  ld_ext = {24'd0, ld_byte};
      3'b101:  ld_ext = {16'd0, ld_half};
      default: ld_ext = mem_rdata_i;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (req_i) begin
          state_d = (illegal || misal) ? S_ERR : S_REQ;
        end
      end
      S_REQ: begin
        if (mem_ready_i) begin
          state_d = S_DONE;
        end else if (cnt_inc == CW'(TIMEOUT_CYCLES)) begin
          state_d = S_ERR;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    done_o    = (state_q == S_DONE);
    err_o     = (state_q == S_ERR);
    busy_o    = (state_q != S_IDLE);
    mem_req_o = (state_q == S_REQ);
  end

  always_comb begin
    f3_d        = f3_q;
    off_d       = off_q;
    cnt_d       = cnt_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_be_d    = mem_be_q;
    mem_wdata_d = mem_wdata_q;
    rdata_d     = rdata_q;
    if ((state_q == S_IDLE) && req_i) begin
      f3_d        = funct3_i;
      off_d       = addr_i[1:0];
      cnt_d       = '0;
      mem_we_d    = we_i;
      mem_addr_d  = {addr_i[31:2], 2'b00};
      mem_be_d    = lane_be;
      mem_wdata_d = lane_wdata;
    end
    if (state_q == S_REQ) begin
      cnt_d = cnt_inc;
      if (mem_ready_i && !mem_we_q) begin
        rdata_d = ld_ext;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      f3_q        <= '0;
      off_q       <= '0;
      cnt_q       <= '0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_be_q    <= '0;
      mem_wdata_q <= '0;
      rdata_q     <= '0;
    end else begin
      f3_q        <= f3_d;
      off_q       <= off_d;
      cnt_q       <= cnt_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_be_q    <= mem_be_d;
      mem_wdata_q <= mem_wdata_d;
      rdata_q     <= rdata_d;
    end
  end

  assign mem_we_o    = mem_we_q;
  assign mem_addr_o  = mem_addr_q;
  assign mem_be_o    = mem_be_q;
  assign mem_wdata_o = mem_wdata_q;
  assign rdata_o     = rdata_q;

endmodule

`default_nettype wire

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: directed vector table, multi-cycle sequences and a random model check.
`default_nettype none

module tb_load_store_unit;

  localparam int TO = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic        req;
  logic        we;
  logic [2:0]  f3;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        done;
  logic        err;
  logic        busy;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic        mem_ready;
  logic [31:0] mem_rdata;

  int n_cmp = 0;
  int n_mis = 0;
  logic [31:0] model_rdata;

  load_store_unit #(.TIMEOUT_CYCLES(TO)) dut (
    .clk_i(clk), .rst_i(rst), .req_i(req), .we_i(we), .funct3_i(f3),
    .addr_i(addr), .wdata_i(wdata), .rdata_o(rdata), .done_o(done),
    .err_o(err), .busy_o(busy), .mem_req_o(mem_req), .mem_we_o(mem_we),
    .mem_addr_o(mem_addr), .mem_be_o(mem_be), .mem_wdata_o(mem_wdata),
    .mem_ready_i(mem_ready), .mem_rdata_i(mem_rdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] mr;
    int          dly;
    logic        err;
    logic [3:0]  be;
    logic [31:0] rd;
  } vec_t;

  vec_t vt[12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: size/alignment arithmetic straight from the access rules
  function automatic void model(input logic w, input logic [2:0] f, input logic [31:0] a,
                                input logic [31:0] mr, output logic e, output logic [3:0] be,
                                output logic [31:0] rd);
    int size, off, base;
    logic [31:0] mask, v;
    e = (f == 3'd3) || (f == 3'd6) || (f == 3'd7) || (w && f[2]);
    size = e ? 1 : (1 << f[1:0]);
    off = int'(a[1:0]);
`ifdef MISALIGN_TRAP_EN
    if ((off % size) != 0) e = 1'b1;
`endif
    base = off - (off % size);
    be = 4'(((1 << size) - 1) << base);
    if (!e && !w) begin
      mask = (size == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * size)) - 32'd1);
      v = (mr >> (8 * base)) & mask;
      if (!f[2] && size < 4 && v[8 * size - 1]) v = v | ~mask;
      model_rdata = v;
    end
    rd = model_rdata;
  endfunction

  task automatic run_access(input logic w, input logic [2:0] f, input logic [31:0] a,
                            input logic [31:0] wd, input logic [31:0] mr, input int dly,
                            input logic exp_err, input logic [3:0] exp_be,
                            input logic [31:0] exp_rd, input logic noise);
    int base;
    req = 1'b1; we = w; f3 = f; addr = a; wdata = wd;
    mem_ready = noise ? 1'($urandom % 2) : 1'b0;
    tick();
    req = 1'b0; mem_ready = 1'b0;
    if (exp_err) begin
      chk("err_pulse", 32'(err), 32'd1);
      chk("err_no_memreq", 32'(mem_req), 32'd0);
      chk("err_no_done", 32'(done), 32'd0);
      tick();
      chk("err_once", 32'(err), 32'd0);
      chk("err_busy_clear", 32'(busy), 32'd0);
      chk("err_rdata_hold", rdata, exp_rd);
      return;
    end
    base = 0;
    for (int b = 3; b >= 0; b--) if (exp_be[b]) base = b;
    for (int i = 0; i <= dly; i++) begin
      chk("mem_req", 32'(mem_req), 32'd1);
      chk("mem_addr", mem_addr, {a[31:2], 2'b00});
      chk("mem_be", 32'(mem_be), 32'(exp_be));
      chk("mem_we", 32'(mem_we), 32'(w));
      chk("no_early_done", 32'(done), 32'd0);
      if (w) begin
        for (int b = 0; b < 4; b++) begin
          if (exp_be[b]) chk("mem_wdata_lane", 32'(mem_wdata[8*b +: 8]), 32'(wd[8*(b-base) +: 8]));
        end
      end
      if (i < dly) begin
        if (noise) begin
          req = 1'b1; we = ~w; f3 = 3'($urandom); addr = $urandom;
        end
        tick();
      end
    end
    req = 1'b0; mem_ready = 1'b1; mem_rdata = mr;
    tick();
    mem_ready = 1'b0; mem_rdata = $urandom;
    chk("done_pulse", 32'(done), 32'd1);
    chk("done_no_err", 32'(err), 32'd0);
    chk("done_memreq_low", 32'(mem_req), 32'd0);
    chk("rdata", rdata, exp_rd);
    tick();
    chk("done_once", 32'(done), 32'd0);
    chk("idle_busy", 32'(busy), 32'd0);
    chk("rdata_held", rdata, exp_rd);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_rdata"}, rdata, 32'd0);
    chk({tag, "_done"}, 32'(done), 32'd0);
    chk({tag, "_err"}, 32'(err), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_mem_req"}, 32'(mem_req), 32'd0);
    chk({tag, "_mem_we"}, 32'(mem_we), 32'd0);
    chk({tag, "_mem_addr"}, mem_addr, 32'd0);
    chk({tag, "_mem_be"}, 32'(mem_be), 32'd0);
    chk({tag, "_mem_wdata"}, mem_wdata, 32'd0);
  endtask

  initial begin
    logic        e;
    logic [3:0]  be;
    logic [31:0] rd, a, wd, mr;
    logic [2:0]  f;
    logic        w;

    vt[0]  = '{1'b1, 3'b000, 32'h0000_1003, 32'h1234_56A5, 32'h0, 0, 1'b0, 4'b1000, 32'h0};
    vt[1]  = '{1'b0, 3'b000, 32'h0000_2002, 32'h0, 32'h0080_0000, 0, 1'b0, 4'b0100, 32'hFFFF_FF80};
    vt[2]  = '{1'b0, 3'b100, 32'h0000_2002, 32'h0, 32'h0080_0000, 0, 1'b0, 4'b0100, 32'h0000_0080};
    vt[3]  = '{1'b0, 3'b101, 32'h0000_2002, 32'h0, 32'h0080_0000, 1, 1'b0, 4'b1100, 32'h0000_0080};
    vt[4]  = '{1'b0, 3'b010, 32'h0000_3000, 32'h0, 32'hDEAD_BEEF, 5, 1'b0, 4'b1111, 32'hDEAD_BEEF};
    vt[5]  = '{1'b0, 3'b011, 32'h0000_3000, 32'h0, 32'h0, 0, 1'b1, 4'b0000, 32'hDEAD_BEEF};
    vt[6]  = '{1'b1, 3'b100, 32'h0000_3000, 32'h0, 32'h0, 0, 1'b1, 4'b0000, 32'hDEAD_BEEF};
    vt[7]  = '{1'b1, 3'b001, 32'h0000_0012, 32'hCAFE_BABE, 32'h0, 2, 1'b0, 4'b1100, 32'hDEAD_BEEF};
    vt[8]  = '{1'b0, 3'b001, 32'h0000_0006, 32'h0, 32'h8001_0000, 2, 1'b0, 4'b1100, 32'hFFFF_8001};
    vt[9]  = '{1'b1, 3'b010, 32'h0000_0044, 32'h89AB_CDEF, 32'h0, 1, 1'b0, 4'b1111, 32'hFFFF_8001};
`ifdef MISALIGN_TRAP_EN
    vt[10] = '{1'b0, 3'b001, 32'h0000_0001, 32'h0, 32'h0000_7FFE, 0, 1'b1, 4'b0000, 32'hFFFF_8001};
    vt[11] = '{1'b0, 3'b010, 32'h0000_0003, 32'h0, 32'h1122_3344, 0, 1'b1, 4'b0000, 32'hFFFF_8001};
`else
    vt[10] = '{1'b0, 3'b001, 32'h0000_0001, 32'h0, 32'h0000_7FFE, 0, 1'b0, 4'b0011, 32'h0000_7FFE};
    vt[11] = '{1'b0, 3'b010, 32'h0000_0003, 32'h0, 32'h1122_3344, 0, 1'b0, 4'b1111, 32'h1122_3344};
`endif

    rst = 1'b0; req = 1'b0; we = 1'b0; f3 = 3'd0; addr = 32'd0; wdata = 32'd0;
    mem_ready = 1'b0; mem_rdata = 32'd0;
    tick(); tick();
    chk_all_zero("reset");
    rst = 1'b1;
    tick();

    for (int i = 0; i < 12; i++) begin
      run_access(vt[i].we, vt[i].f3, vt[i].addr, vt[i].wdata, vt[i].mr, vt[i].dly,
                 vt[i].err, vt[i].be, vt[i].rd, 1'b0);
    end

    // Memory never answers: err exactly after TO request cycles
    req = 1'b1; we = 1'b0; f3 = 3'b010; addr = 32'h0000_0100;
    tick();
    req = 1'b0;
    for (int i = 1; i <= TO; i++) begin
      chk("timeout_mem_req", 32'(mem_req), 32'd1);
      chk("timeout_no_err_yet", 32'(err), 32'd0);
      tick();
    end
    chk("timeout_err", 32'(err), 32'd1);
    chk("timeout_mem_req_low", 32'(mem_req), 32'd0);
    chk("timeout_no_done", 32'(done), 32'd0);
    tick();
    chk("timeout_err_once", 32'(err), 32'd0);
    chk("timeout_idle", 32'(busy), 32'd0);

    // Reset asserted during the third request cycle
    req = 1'b1; we = 1'b0; f3 = 3'b010; addr = 32'h0000_3000;
    tick();
    req = 1'b0;
    tick(); tick();
    chk("pre_reset_mem_req", 32'(mem_req), 32'd1);
    rst = 1'b0;
    tick();
    chk_all_zero("midreset");
    rst = 1'b1;
    mem_ready = 1'b1;
    tick();
    mem_ready = 1'b0;
    chk("post_reset_no_done", 32'(done), 32'd0);
    chk("post_reset_no_err", 32'(err), 32'd0);
    model_rdata = 32'd0;
    model(1'b0, 3'b010, 32'h0000_3000, 32'h5A5A_0F0F, e, be, rd);
    run_access(1'b0, 3'b010, 32'h0000_3000, 32'h0, 32'h5A5A_0F0F, 1, e, be, rd, 1'b0);

    for (int n = 0; n < 80; n++) begin
      w  = 1'($urandom % 2);
      f  = 3'($urandom_range(0, 7));
      a  = $urandom;
      wd = $urandom;
      mr = $urandom;
      model(w, f, a, mr, e, be, rd);
      run_access(w, f, a, wd, mr, int'($urandom_range(0, 3)), e, be, rd, 1'b1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule

`default_nettype wire
